dtc_vote_accum: RTL and testbench
=================================

# dtc_vote_accum

Streaming vote accumulator downstream of the `dtc_*` decision-tree classifiers. Each cycle it accepts one 2-bit class prediction over a valid/ready handshake and keeps a per-class vote count. After `WINDOW` predictions, or on an early `flush`, it emits the majority class, its vote count and a tie flag. This turns the per-sample combinational tree output into a smoothed, windowed decision.

## Interface
- `WINDOW`, default 16: predictions per decision window; legal range 1..255.
- `CNT_W`, default `$clog2(WINDOW+1)`: width of the per-class and sample counters; derived, not overridden.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_class` carries a prediction.
- `in_ready`  out  1  block accepts a prediction this cycle.
- `in_class`  in  2  class prediction (the tree `outp`).
- `flush`  in  1  close the current window early.
- `out_valid`  out  1  decision available.
- `out_ready`  in  1  consumer takes the decision.
- `out_class`  out  2  majority class.
- `out_count`  out  CNT_W  votes received by `out_class`.
- `out_total`  out  CNT_W  predictions in the closed window.
- `out_tie`  out  1  another class had the same maximum count.

## Operation
- Two states: ACCUM and EMIT. Reset state is ACCUM.
- Registers:
  - four per-class counters `cnt[0..3]`, each CNT_W bits;
  - sample counter `n`, CNT_W bits;
  - output registers.
- In ACCUM, `in_ready`=1.
  - Accept occurs when `in_valid && in_ready`.
  - On accept, `cnt[in_class]` += 1 and `n` += 1.
  - Counters cannot overflow because `n` ≤ WINDOW.
- The window closes in ACCUM when either condition holds:
  - an accept occurs with `n+1 == WINDOW`; or
  - `flush` is 1 and the post-accept sample count is > 0.
  - A sample accepted in the same cycle as `flush` belongs to the closing window.
  - `flush` with zero samples and no accept is ignored.
- On close, the argmax is computed over the post-update counters.
  - Ties resolve to the lowest class index.
  - `out_tie`=1 if any other class count equals the maximum.
  - `out_class`, `out_count`, `out_total` and `out_tie` are registered.
  - `out_valid` is set, the state moves to EMIT, and all `cnt` and `n` clear to 0 in the same edge.
- In EMIT, `in_ready`=0 and `flush` is ignored.
  - Outputs hold stable while `out_valid && !out_ready`.
  - On `out_valid && out_ready`: `out_valid` clears and the state returns to ACCUM.
- `in_class` is only sampled on accept. Values on it at other times have no effect.

## Timing
- Reset (`rst`=1 at a rising edge) drives:
  - state to ACCUM;
  - `cnt`, `n` to 0;
  - `out_valid` to 0;
  - `out_class`, `out_count`, `out_total`, `out_tie` to 0.
- `in_ready` is combinationally 0 while `rst`=1.
- Reset mid-window discards the partial window; no decision is emitted.
- Reset during EMIT drops the pending decision.
- Latency: when the closing accept or flush happens in cycle t, `out_valid`=1 in cycle t+1.
- Throughput: one decision costs WINDOW accept cycles plus at least 1 EMIT cycle.
  - `in_ready` is 0 for every cycle spent in EMIT, so back-to-back windows have a minimum one-cycle bubble.
- `in_ready` depends only on state and `rst`, never on `in_valid`.
- `out_valid` is registered.
- No combinational path from `out_ready` to `in_ready` within the same cycle. `in_ready` rises in the cycle after the handshake.
- With WINDOW=1, every accept closes a window: `out_count`=`out_total`=1, `out_tie`=0.

## Test plan
- WINDOW=4, `out_ready`=1, classes 2,2,1,2 on consecutive cycles. Expected: `out_valid` one cycle after the 4th accept, with `out_class`=2, `out_count`=3, `out_total`=4, `out_tie`=0; `in_ready`=0 for exactly 1 cycle.
- WINDOW=4, classes 3,1,3,1. Expected: `out_class`=1, `out_count`=2, `out_tie`=1 (lowest index wins).
- WINDOW=16, three accepts of class 0, then `flush` with no `in_valid`. Expected: `out_class`=0, `out_count`=3, `out_total`=3, `out_tie`=0. Counters are clear: the next window's decision reflects only new samples.
- WINDOW=16, `flush` in the same cycle as the 2nd accept (classes 1,3). Expected: `out_total`=2, `out_class`=1, `out_tie`=1. Also: `flush` on an empty window produces no `out_valid`.
- Backpressure: `out_ready`=0 for 5 cycles after a close with `in_valid` held high. Expected: outputs stable, `in_ready`=0 throughout, no samples accepted. After `out_ready`=1: `out_valid` drops next cycle and `in_ready` returns to 1.
- `rst` pulsed after 2 of 4 samples, then 4 samples of class 3. Expected: a single decision with `out_class`=3, `out_count`=4, `out_total`=4; all outputs 0 while `rst` is held.

Source files
------------

// File: rtl/dtc_vote_accum.sv
// Windowed majority vote over the 2-bit predictions of a dtc_* classifier.
// Emits argmax class, its vote count, window size and a tie flag per window.
module dtc_vote_accum #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_class,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_class,
  output logic [CNT_W-1:0] out_count,
  output logic [CNT_W-1:0] out_total,
  output logic             out_tie
);

  typedef enum logic {ACCUM, EMIT} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [CNT_W-1:0] n_q, n_d;
  logic             out_valid_q;
  logic [1:0]       out_class_q;
  logic [CNT_W-1:0] out_count_q, out_total_q;
  logic             out_tie_q;

  logic             accept, close;
  logic [1:0]       best_idx;
  logic [CNT_W-1:0] best_cnt;
  logic             tie;

  assign in_ready = (state_q == ACCUM) && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i] + CNT_W'(accept && (in_class == 2'(i)));
    end
    n_d = n_q + CNT_W'(accept);
  end

  // The closing sample (accepted alongside flush or as the WINDOW-th) is
  // already folded into cnt_d/n_d, so the decision is taken on those.
  assign close = (state_q == ACCUM) && !rst &&
                 ((accept && (n_d == CNT_W'(WINDOW))) || (flush && (n_d != '0)));

  // Strict '>' keeps the lowest index on equal counts.
  always_comb begin
    best_idx = 2'd0;
    best_cnt = cnt_d[0];
    tie      = 1'b0;
    for (int i = 1; i < 4; i++) begin
      if (cnt_d[i] > best_cnt) begin
        best_cnt = cnt_d[i];
        best_idx = 2'(i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if ((2'(i) != best_idx) && (cnt_d[i] == best_cnt)) tie = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      n_q         <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      out_valid_q <= 1'b0;
      out_class_q <= 2'd0;
      out_count_q <= '0;
      out_total_q <= '0;
      out_tie_q   <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (close) begin
            out_valid_q <= 1'b1;
            out_class_q <= best_idx;
            out_count_q <= best_cnt;
            out_total_q <= n_d;
            out_tie_q   <= tie;
            state_q     <= EMIT;
            n_q         <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
          end else begin
            n_q <= n_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_count = out_count_q;
  assign out_total = out_total_q;
  assign out_tie   = out_tie_q;

endmodule

// File: tb/tb_dtc_vote_accum.sv
// Scoreboard bench for dtc_vote_accum: directed scenarios plus random traffic
// against a window-list reference model.
module tb_dtc_vote_accum;

  localparam int WINDOW = 4;
  localparam int CNT_W  = $clog2(WINDOW + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_class = 2'd0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [1:0]       out_class;
  logic [CNT_W-1:0] out_count;
  logic [CNT_W-1:0] out_total;
  logic             out_tie;

  dtc_vote_accum #(.WINDOW(WINDOW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .out_count(out_count), .out_total(out_total), .out_tie(out_tie)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cls;
    int cnt;
    int tot;
    int tie;
  } dec_t;

  dec_t exp_q[$];
  int   win[$];
  bit   busy = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Majority decision computed directly from the list of window samples.
  task automatic model_close();
    int   k[4];
    dec_t d;
    for (int i = 0; i < 4; i++) k[i] = 0;
    foreach (win[j]) k[win[j]]++;
    d.cls = 0;
    for (int i = 1; i < 4; i++) if (k[i] > k[d.cls]) d.cls = i;
    d.cnt = k[d.cls];
    d.tot = win.size();
    d.tie = 0;
    for (int i = 0; i < 4; i++) if (i != d.cls && k[i] == d.cnt) d.tie = 1;
    exp_q.push_back(d);
    win.delete();
    busy = 1'b1;
  endtask

  task automatic post_edge_check();
    @(posedge clk);
    #1;
    chk("in_ready", int'(in_ready), int'(!busy && !rst));
    chk("out_valid", int'(out_valid), int'(busy));
  endtask

  task automatic step(input bit v, input int c, input bit f, input bit r);
    post_edge_check();
    rst       = 1'b0;
    in_valid  = v;
    in_class  = 2'(c);
    flush     = f;
    out_ready = r;
    if (busy) begin
      if (r) busy = 1'b0;
    end else begin
      if (v) win.push_back(c);
      if ((v && win.size() == WINDOW) || (f && win.size() > 0)) model_close();
    end
  endtask

  task automatic apply_reset(input int cycles);
    post_edge_check();
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_class  = 2'($urandom_range(3));
    flush     = 1'($urandom_range(1));
    out_ready = 1'($urandom_range(1));
    win.delete();
    exp_q.delete();
    busy = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_class", int'(out_class), 0);
      chk("rst_out_count", int'(out_count), 0);
      chk("rst_out_total", int'(out_total), 0);
      chk("rst_out_tie", int'(out_tie), 0);
    end
  endtask

  // Monitor: every cycle a decision is presented it must match the oldest
  // outstanding expectation; it retires on the handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out_valid: got 1 expected 0 at %0t", $time);
      end else begin
        chk("out_class", int'(out_class), exp_q[0].cls);
        chk("out_count", int'(out_count), exp_q[0].cnt);
        chk("out_total", int'(out_total), exp_q[0].tot);
        chk("out_tie", int'(out_tie), exp_q[0].tie);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seq[4];
    apply_reset(2);

    // Majority 2 (3 votes), then one bubble cycle.
    seq = '{2, 2, 1, 2};
    foreach (seq[i]) step(1, seq[i], 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // Tie between 1 and 3 resolves to 1.
    seq = '{3, 1, 3, 1};
    foreach (seq[i]) step(1, seq[i], 0, 1);
    step(0, 0, 0, 1);

    // Early flush after three class-0 samples, then a fresh window.
    repeat (3) step(1, 0, 0, 1);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    seq = '{1, 1, 2, 1};
    foreach (seq[i]) step(1, seq[i], 0, 1);
    step(0, 0, 0, 1);

    // Flush together with the 2nd accept; then flushes on an empty window.
    step(1, 1, 0, 1);
    step(1, 3, 1, 1);
    step(0, 0, 0, 1);
    repeat (3) step(0, 2, 1, 1);

    // Backpressure with in_valid held high.
    seq = '{0, 3, 3, 2};
    foreach (seq[i]) step(1, seq[i], 0, 0);
    repeat (5) step(1, 1, 1, 0);
    step(1, 1, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // Reset mid-window discards the partial window.
    step(1, 1, 0, 1);
    step(1, 2, 0, 1);
    apply_reset(3);
    repeat (4) step(1, 3, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // Random traffic, occasional resets including during EMIT.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(99) == 0) apply_reset(1 + $urandom_range(2));
      else step($urandom_range(99) < 70, $urandom_range(3),
                $urandom_range(99) < 10, $urandom_range(99) < 60);
    end

    repeat (4) step(0, 0, 0, 1);
    #10;
    chk("drained_queue", exp_q.size(), 0);
    chk("drained_busy", int'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
